// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM encoding and checksum helper for the UART command path.
// Also consumed by the uart_tx-side responder.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_DEF   = 8'hA5;
    localparam logic [7:0] ACK_BYTE   = 8'h06;
    localparam logic [7:0] NAK_BYTE   = 8'h15;
    localparam int         CMD_WR_BIT = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_DATA,
        ST_GET_CHK,
        ST_EXEC,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

    function automatic logic chk_ok(
        input logic [7:0] cmd,
        input logic [7:0] data,
        input logic [7:0] chk
    );
        return (cmd ^ data) == chk;
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte timeout counter: counts while enabled, saturates,
// and flags expiry on the TIMEOUT_CYCLES-th silent cycle.
module uart_byte_timer #(
    parameter int TIMEOUT_CYCLES = 104160
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIM    = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LIM_M1 = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != LIM) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expire = enable && (cnt >= LIM_M1);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame parser: SYNC/CMD/DATA/CHK -> one register access and one
// response byte; owns the inter-byte timeout and error counter.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int          ADDR_W         = 4,
    parameter int          TIMEOUT_CYCLES = 104160,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    state_t     state;
    logic [7:0] cmd_r;
    logic [7:0] data_r;
    logic       in_get;
    logic       expire;
    logic       good;
    logic       err_evt;

    assign in_get = (state == ST_GET_CMD) ||
                    (state == ST_GET_DATA) ||
                    (state == ST_GET_CHK);
    assign good   = chk_ok(cmd_r, data_r, rx_byte);
    assign busy   = (state != ST_IDLE);

    uart_byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_get || rx_valid),
        .enable (in_get),
        .expire (expire)
    );

    // All error sources in a cycle collapse into one increment.
    always_comb begin
        err_evt = 1'b0;
        if (in_get && !rx_valid && expire)
            err_evt = 1'b1;
        if (state == ST_GET_CHK && rx_valid && !good)
            err_evt = 1'b1;
        if (rx_valid && (state == ST_EXEC ||
                         state == ST_RD_WAIT ||
                         state == ST_RESP))
            err_evt = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_r     <= '0;
            data_r    <= '0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            tx_byte   <= '0;
            tx_valid  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            if (err_evt && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            unique case (state)
                ST_IDLE: begin
                    if (rx_valid && rx_byte == SYNC_BYTE)
                        state <= ST_GET_CMD;
                end
                ST_GET_CMD: begin
                    if (rx_valid) begin
                        cmd_r <= rx_byte;
                        state <= ST_GET_DATA;
                    end else if (expire) begin
                        state <= ST_IDLE;
                    end
                end
                ST_GET_DATA: begin
                    if (rx_valid) begin
                        data_r <= rx_byte;
                        state  <= ST_GET_CHK;
                    end else if (expire) begin
                        state <= ST_IDLE;
                    end
                end
                ST_GET_CHK: begin
                    if (rx_valid && good) begin
                        state    <= ST_EXEC;
                        reg_addr <= cmd_r[ADDR_W-1:0];
                        if (cmd_r[CMD_WR_BIT]) begin
                            reg_wr_en <= 1'b1;
                            reg_wdata <= data_r;
                        end else begin
                            reg_rd_en <= 1'b1;
                        end
                    end else if (rx_valid) begin
                        state    <= ST_RESP;
                        tx_byte  <= NAK_BYTE;
                        tx_valid <= 1'b1;
                    end else if (expire) begin
                        state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (cmd_r[CMD_WR_BIT]) begin
                        state    <= ST_RESP;
                        tx_byte  <= ACK_BYTE;
                        tx_valid <= 1'b1;
                    end else begin
                        state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    state    <= ST_RESP;
                    tx_byte  <= reg_rdata;
                    tx_valid <= 1'b1;
                end
                ST_RESP: begin
                    if (tx_ready) begin
                        state    <= ST_IDLE;
                        tx_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a short timeout.
// Register file model returns 5A at address 3.
module tb_uart_cmd_ctrl;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(
        .ADDR_W(4),
        .TIMEOUT_CYCLES(TO),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_byte(rx_byte),
        .rx_valid(rx_valid),
        .reg_wr_en(reg_wr_en),
        .reg_rd_en(reg_rd_en),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .tx_byte(tx_byte),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .err_cnt(err_cnt)
    );

    always @(posedge clk) begin
        if (reg_rd_en)
            reg_rdata <= (reg_addr == 4'd3) ? 8'h5A : {4'hC, reg_addr};
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] d,
                         input logic [7:0] k);
        send(8'hA5);
        send(c);
        send(d);
        send(k);
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_wr"}, 32'(reg_wr_en), 0);
        check({tag, "_rd"}, 32'(reg_rd_en), 0);
        check({tag, "_addr"}, 32'(reg_addr), 0);
        check({tag, "_wdata"}, 32'(reg_wdata), 0);
        check({tag, "_txb"}, 32'(tx_byte), 0);
        check({tag, "_txv"}, 32'(tx_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_err"}, 32'(err_cnt), 0);
    endtask

    task automatic handshake(input string tag);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check({tag, "_hs_txv"}, 32'(tx_valid), 0);
        check({tag, "_hs_busy"}, 32'(busy), 0);
    endtask

    task automatic write_ack(input string tag);
        frame(8'h85, 8'h3C, 8'hB9);
        check({tag, "_wr"}, 32'(reg_wr_en), 1);
        step();
        check({tag, "_txv"}, 32'(tx_valid), 1);
        check({tag, "_ack"}, 32'(tx_byte), 32'h06);
        handshake(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        all_zero("rst_async");
        step();
        all_zero("rst_held");
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rx_byte = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        #1;
        all_zero("reset");
        step();
        rst = 1'b0;
        step();

        // Write frame
        frame(8'h85, 8'h3C, 8'hB9);
        check("wr_strobe", 32'(reg_wr_en), 1);
        check("wr_addr", 32'(reg_addr), 5);
        check("wr_data", 32'(reg_wdata), 32'h3C);
        check("wr_nord", 32'(reg_rd_en), 0);
        check("wr_txv0", 32'(tx_valid), 0);
        step();
        check("wr_once", 32'(reg_wr_en), 0);
        check("wr_txv", 32'(tx_valid), 1);
        check("wr_ack", 32'(tx_byte), 32'h06);
        check("wr_err", 32'(err_cnt), 0);
        handshake("wr");

        // Read frame
        frame(8'h03, 8'h00, 8'h03);
        check("rd_strobe", 32'(reg_rd_en), 1);
        check("rd_addr", 32'(reg_addr), 3);
        check("rd_nowr", 32'(reg_wr_en), 0);
        step();
        check("rd_once", 32'(reg_rd_en), 0);
        check("rd_wait_txv", 32'(tx_valid), 0);
        step();
        check("rd_txv", 32'(tx_valid), 1);
        check("rd_data", 32'(tx_byte), 32'h5A);
        handshake("rd");

        // Bad checksum
        frame(8'h85, 8'h3C, 8'h00);
        exp_err++;
        check("nak_wr", 32'(reg_wr_en), 0);
        check("nak_rd", 32'(reg_rd_en), 0);
        check("nak_txv", 32'(tx_valid), 1);
        check("nak_byte", 32'(tx_byte), 32'h15);
        check("nak_err", 32'(err_cnt), 32'(exp_err));
        handshake("nak");

        // Timeout after CMD
        send(8'hA5);
        send(8'h85);
        repeat (TO - 1) step();
        check("to_pre_busy", 32'(busy), 1);
        check("to_pre_err", 32'(err_cnt), 32'(exp_err));
        step();
        exp_err++;
        check("to_busy", 32'(busy), 0);
        check("to_err", 32'(err_cnt), 32'(exp_err));
        write_ack("after_to");

        // Byte arriving on the expiry cycle is accepted
        send(8'hA5);
        send(8'h85);
        repeat (TO - 1) step();
        send(8'h3C);
        check("edge_busy", 32'(busy), 1);
        check("edge_err", 32'(err_cnt), 32'(exp_err));
        send(8'hB9);
        check("edge_wr", 32'(reg_wr_en), 1);
        step();
        check("edge_ack", 32'(tx_byte), 32'h06);
        handshake("edge");

        // Backpressure with a dropped SYNC during RESP
        frame(8'h85, 8'h3C, 8'hB9);
        step();
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin
                rx_byte  = 8'hA5;
                rx_valid = 1'b1;
            end
            step();
            rx_valid = 1'b0;
            check("bp_txv", 32'(tx_valid), 1);
            check("bp_txb", 32'(tx_byte), 32'h06);
        end
        exp_err++;
        check("bp_err", 32'(err_cnt), 32'(exp_err));
        handshake("bp");
        send(8'h85);
        send(8'h3C);
        send(8'hB9);
        check("drop_no_sync", 32'(busy), 0);
        check("drop_no_wr", 32'(reg_wr_en), 0);

        // Reset mid-frame
        send(8'hA5);
        send(8'h85);
        do_reset();
        write_ack("post_rst1");

        // Reset mid-RESP
        frame(8'h85, 8'h3C, 8'hB9);
        step();
        check("pre_rst_txv", 32'(tx_valid), 1);
        do_reset();
        write_ack("post_rst2");

        // Error counter saturation
        frame(8'h85, 8'h3C, 8'hB9);
        step();
        rx_byte  = 8'h11;
        rx_valid = 1'b1;
        repeat (254) step();
        check("sat_fe", 32'(err_cnt), 32'hFE);
        step();
        check("sat_ff", 32'(err_cnt), 32'hFF);
        repeat (45) step();
        rx_valid = 1'b0;
        check("sat_hold", 32'(err_cnt), 32'hFF);
        check("sat_txv", 32'(tx_valid), 1);
        handshake("sat");
        check("sat_final", 32'(err_cnt), 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
